// File: rtl/regfile_access_sequencer.sv
// Owns the register file's single shared port: issues one operand read or one buffered
// writeback per cycle, and forwards pending writebacks so decode never sees a stale value.
module regfile_access_sequencer #(
    parameter int XLEN       = 64,
    parameter int WB_DEPTH   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [4:0]                  rs1,
    input  logic [4:0]                  rs2,
    output logic                        rd_rsp_valid,
    output logic [XLEN-1:0]             rs1_data,
    output logic [XLEN-1:0]             rs2_data,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [4:0]                  wb_rd,
    input  logic [XLEN-1:0]             wb_data,
    output logic                        rf_read_en,
    output logic [4:0]                  rf_data_read_1,
    output logic [4:0]                  rf_data_read_2,
    output logic [4:0]                  rf_write_en,
    output logic [XLEN-1:0]             rf_data_in,
    input  logic [XLEN-1:0]             rf_data_out_1,
    input  logic [XLEN-1:0]             rf_data_out_2,
    output logic [$clog2(WB_DEPTH):0]   wb_count
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    logic [4:0]       fifo_rd_r   [WB_DEPTH];
    logic [XLEN-1:0]  fifo_data_r [WB_DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [ST_W-1:0]  starve_r;

    logic             rsp_valid_r;
    logic             zero1_r;
    logic             zero2_r;
    logic             hit1_r;
    logic             hit2_r;
    logic [XLEN-1:0]  fwd1_r;
    logic [XLEN-1:0]  fwd2_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             read_issue_s;
    logic             write_issue_s;
    logic             push_s;
    logic [WB_DEPTH-1:0] live_s;
    logic [4:0]       age_rd_s   [WB_DEPTH];
    logic [XLEN-1:0]  age_data_s [WB_DEPTH];
    logic             hit1_s;
    logic             hit2_s;
    logic [XLEN-1:0]  fwd1_s;
    logic [XLEN-1:0]  fwd2_s;

    assign wb_count     = count_r;
    assign rd_rsp_valid = rsp_valid_r;

    // Handshakes and the per-cycle read/write arbitration decision
    always_comb begin
        fifo_full_s   = (count_r == CNT_W'(WB_DEPTH));
        fifo_empty_s  = (count_r == {CNT_W{1'b0}});
        wb_ready      = ~fifo_full_s;
        rd_req_ready  = ~fifo_full_s & (starve_r < ST_W'(STARVE_MAX));
        read_issue_s  = rd_req_valid & rd_req_ready;
        write_issue_s = ~read_issue_s & ~fifo_empty_s;
        push_s        = wb_valid & wb_ready & (wb_rd != 5'd0);
    end

    // Shared RF port drive: read, write of the FIFO head, or idle
    always_comb begin
        rf_read_en     = 1'b0;
        rf_data_read_1 = 5'd0;
        rf_data_read_2 = 5'd0;
        rf_write_en    = 5'd0;
        rf_data_in     = {XLEN{1'b0}};
        if (read_issue_s) begin
            rf_read_en     = 1'b1;
            rf_data_read_1 = rs1;
            rf_data_read_2 = rs2;
        end else if (write_issue_s) begin
            rf_write_en = fifo_rd_r[head_r];
            rf_data_in  = fifo_data_r[head_r];
        end else begin
            rf_read_en = 1'b0;
        end
    end

    // FIFO entries re-indexed by age (0 = oldest) with their occupancy flags
    always_comb begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            live_s[i]     = (CNT_W'(i) < count_r);
            age_rd_s[i]   = fifo_rd_r[head_r + PTR_W'(i)];
            age_data_s[i] = fifo_data_r[head_r + PTR_W'(i)];
        end
    end

    // Forwarding lookup: later (younger) matches override earlier ones
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        fwd1_s = {XLEN{1'b0}};
        fwd2_s = {XLEN{1'b0}};
        for (int i = 0; i < WB_DEPTH; i++) begin
            fwd1_s = (live_s[i] && (age_rd_s[i] == rs1)) ? age_data_s[i] : fwd1_s;
            hit1_s = hit1_s | (live_s[i] && (age_rd_s[i] == rs1));
            fwd2_s = (live_s[i] && (age_rd_s[i] == rs2)) ? age_data_s[i] : fwd2_s;
            hit2_s = hit2_s | (live_s[i] && (age_rd_s[i] == rs2));
        end
        fwd1_s = (push_s && (wb_rd == rs1)) ? wb_data : fwd1_s;
        hit1_s = hit1_s | (push_s && (wb_rd == rs1));
        fwd2_s = (push_s && (wb_rd == rs2)) ? wb_data : fwd2_s;
        hit2_s = hit2_s | (push_s && (wb_rd == rs2));
    end

    // Writeback FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < WB_DEPTH; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_rd_r[tail_r]   <= wb_rd;
                fifo_data_r[tail_r] <= wb_data;
                tail_r              <= tail_r + PTR_W'(1'b1);
            end
            if (write_issue_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(write_issue_s);
        end
    end

    // Starvation counter bounds how long reads may hold off a pending writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_r <= {ST_W{1'b0}};
        end else if (write_issue_s || fifo_empty_s) begin
            starve_r <= {ST_W{1'b0}};
        end else if (read_issue_s) begin
            starve_r <= starve_r + ST_W'(1'b1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Capture forwarding result alongside the RF read for the response cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            zero1_r     <= 1'b0;
            zero2_r     <= 1'b0;
            hit1_r      <= 1'b0;
            hit2_r      <= 1'b0;
            fwd1_r      <= {XLEN{1'b0}};
            fwd2_r      <= {XLEN{1'b0}};
        end else begin
            rsp_valid_r <= read_issue_s;
            if (read_issue_s) begin
                zero1_r <= (rs1 == 5'd0);
                zero2_r <= (rs2 == 5'd0);
                hit1_r  <= hit1_s;
                hit2_r  <= hit2_s;
                fwd1_r  <= fwd1_s;
                fwd2_r  <= fwd2_s;
            end
        end
    end

    // Operand response mux: x0, forwarded value, or RF read data
    always_comb begin
        rs1_data = {XLEN{1'b0}};
        rs2_data = {XLEN{1'b0}};
        if (rsp_valid_r && !zero1_r) begin
            rs1_data = hit1_r ? fwd1_r : rf_data_out_1;
        end else begin
            rs1_data = {XLEN{1'b0}};
        end
        if (rsp_valid_r && !zero2_r) begin
            rs2_data = hit2_r ? fwd2_r : rf_data_out_2;
        end else begin
            rs2_data = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench for regfile_access_sequencer: RF environment model, architectural-state reference
// and queue-based scoreboard checked by a negedge monitor; directed plus random stimulus.
module tb_regfile_access_sequencer;
    localparam int XLEN       = 64;
    localparam int WB_DEPTH   = 4;
    localparam int STARVE_MAX = 4;

    typedef struct { logic [63:0] d1; logic [63:0] d2; } rsp_t;
    typedef struct { logic [4:0] rd; logic [63:0] data; } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req_valid, rd_req_ready, rd_rsp_valid;
    logic [4:0]  rs1, rs2, wb_rd;
    logic [63:0] rs1_data, rs2_data, wb_data;
    logic        wb_valid, wb_ready, rf_read_en;
    logic [4:0]  rf_data_read_1, rf_data_read_2, rf_write_en;
    logic [63:0] rf_data_in, rf_data_out_1, rf_data_out_2;
    logic [2:0]  wb_count;

    logic [63:0] mem [32];
    logic [63:0] seed_val [32];
    logic        mem_load;

    logic [63:0] arch [32];
    rsp_t        rsp_q [$];
    wr_t         wq [$];
    int          starve;
    int          x5_writes;
    int          checks;
    int          errors;

    regfile_access_sequencer #(.XLEN(XLEN), .WB_DEPTH(WB_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1(rs1), .rs2(rs2),
        .rd_rsp_valid(rd_rsp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_read_en(rf_read_en), .rf_data_read_1(rf_data_read_1), .rf_data_read_2(rf_data_read_2),
        .rf_write_en(rf_write_en), .rf_data_in(rf_data_in),
        .rf_data_out_1(rf_data_out_1), .rf_data_out_2(rf_data_out_2),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Register file: registered read data, write when address nonzero
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= seed_val[i];
        end else if (rf_write_en != 5'd0) begin
            mem[rf_write_en] <= rf_data_in;
        end
        if (rf_read_en) begin
            rf_data_out_1 <= mem[rf_data_read_1];
            rf_data_out_2 <= mem[rf_data_read_2];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req_valid = 1'b0;
        wb_valid     = 1'b0;
        rs1          = 5'd0;
        rs2          = 5'd0;
        wb_rd        = 5'd0;
        wb_data      = 64'd0;
    endtask

    // Monitor + reference model: architectural state = RF plus all accepted writebacks
    initial begin : monitor
        rsp_t e;
        wr_t  w;
        logic exp_rdy, rd_acc, wb_acc, was_empty, wrote;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rsp_q.delete();
                wq.delete();
                starve = 0;
                for (int i = 0; i < 32; i++) arch[i] = mem[i];
                arch[0] = 64'd0;
            end else begin
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", rd_rsp_valid, 1);
                    chk("rs1_data", rs1_data, e.d1);
                    chk("rs2_data", rs2_data, e.d2);
                end else begin
                    chk("rsp_spurious", rd_rsp_valid, 0);
                end
                chk("wb_count", wb_count, wq.size());
                exp_rdy = (wq.size() < WB_DEPTH) && (starve < STARVE_MAX);
                chk("rd_req_ready", rd_req_ready, exp_rdy);
                chk("wb_ready", wb_ready, wq.size() < WB_DEPTH);
                rd_acc    = rd_req_valid && exp_rdy;
                wb_acc    = wb_valid && (wq.size() < WB_DEPTH);
                was_empty = (wq.size() == 0);
                wrote     = 1'b0;
                if (rd_acc) begin
                    chk("read_en", rf_read_en, 1);
                    chk("read_addr1", rf_data_read_1, rs1);
                    chk("read_addr2", rf_data_read_2, rs2);
                    chk("no_write_on_read", rf_write_en, 0);
                end else if (!was_empty) begin
                    w = wq.pop_front();
                    wrote = 1'b1;
                    chk("read_en_on_write", rf_read_en, 0);
                    chk("write_addr", rf_write_en, w.rd);
                    chk("write_data", rf_data_in, w.data);
                end else begin
                    chk("idle_read_en", rf_read_en, 0);
                    chk("idle_write_en", rf_write_en, 0);
                    chk("idle_data_in", rf_data_in, 0);
                end
                if (rf_write_en == 5'd5) x5_writes++;
                if (wrote || was_empty) starve = 0;
                else if (rd_acc) starve++;
                if (wb_acc && (wb_rd != 5'd0)) begin
                    wq.push_back('{wb_rd, wb_data});
                    arch[wb_rd] = wb_data;
                end
                if (rd_acc) begin
                    rsp_q.push_back('{(rs1 == 5'd0) ? 64'd0 : arch[rs1],
                                      (rs2 == 5'd0) ? 64'd0 : arch[rs2]});
                end
            end
        end
    end

    // Stimulus: directed scenarios, mid-operation reset, then random traffic
    initial begin : stimulus
        int          reads;
        logic        got_stall;
        logic [63:0] x12_val;
        int          x5_base;
        checks    = 0;
        errors    = 0;
        x5_writes = 0;
        starve    = 0;
        reset     = 1'b0;
        mem_load  = 1'b1;
        for (int i = 0; i < 32; i++) seed_val[i] = {$urandom, $urandom};
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        mem_load = 1'b0;
        #1;
        chk("reset_rsp_valid", rd_rsp_valid, 0);
        chk("reset_rs1_data", rs1_data, 0);
        chk("reset_rs2_data", rs2_data, 0);
        chk("reset_read_en", rf_read_en, 0);
        chk("reset_write_en", rf_write_en, 0);
        chk("reset_data_in", rf_data_in, 0);
        chk("reset_wb_count", wb_count, 0);
        chk("reset_wb_ready", wb_ready, 1);
        chk("reset_rd_ready", rd_req_ready, 1);

        // write x5, let it drain, read it back with x0
        x5_base = x5_writes;
        step(); wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h0000_0000_DEAD_BEEF;
        step(); idle_inputs();
        step(); step();
        step(); rd_req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
        step(); idle_inputs(); #1;
        chk("t1_rsp_valid", rd_rsp_valid, 1);
        chk("t1_rs1", rs1_data, 64'h0000_0000_DEAD_BEEF);
        chk("t1_rs2", rs2_data, 64'd0);
        chk("t1_x5_write_once", x5_writes - x5_base, 1);

        // same-cycle writeback forwarding
        step(); wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h11;
        rd_req_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd5;
        step(); idle_inputs(); #1;
        chk("t2_rs1_fwd", rs1_data, 64'h11);
        chk("t2_rs2", rs2_data, 64'h0000_0000_DEAD_BEEF);
        chk("t2_write_x7", rf_write_en, 5'd7);
        chk("t2_write_data", rf_data_in, 64'h11);

        // youngest of duplicate writebacks wins
        for (int i = 1; i <= 3; i++) begin
            step(); wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'(i);
        end
        step(); wb_valid = 1'b0; rd_req_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd7;
        step(); idle_inputs(); #1;
        chk("t3_rs1_youngest", rs1_data, 64'd3);
        chk("t3_rs2", rs2_data, 64'h11);
        repeat (4) step();

        // fill the FIFO under continuous reads
        for (int i = 0; i < 4; i++) begin
            step(); wb_valid = 1'b1; wb_rd = 5'(10 + i); wb_data = {$urandom, $urandom};
            rd_req_valid = 1'b1; rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
        end
        step(); wb_valid = 1'b0; #1;
        chk("t4_full_count", wb_count, 4);
        chk("t4_full_wb_ready", wb_ready, 0);
        chk("t4_full_rd_ready", rd_req_ready, 0);
        chk("t4_full_write", rf_write_en, 5'd10);
        step(); #1;
        chk("t4_after_count", wb_count, 3);
        rd_req_valid = 1'b0;
        repeat (6) step();

        // starvation limit with one pending writeback
        x12_val = {$urandom, $urandom};
        step(); wb_valid = 1'b1; wb_rd = 5'd12; wb_data = x12_val;
        step(); wb_valid = 1'b0; rd_req_valid = 1'b1; rs1 = 5'd12; rs2 = 5'd3;
        reads = 0;
        got_stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!rd_req_ready) begin
                got_stall = 1'b1;
                chk("t5_stall_write", rf_write_en, 5'd12);
                break;
            end
            reads++;
            step();
        end
        chk("t5_reads_before_stall", reads, STARVE_MAX);
        chk("t5_stall_seen", got_stall, 1);
        step(); #1;
        chk("t5_ready_back", rd_req_ready, 1);
        rd_req_valid = 1'b0;
        repeat (3) step();

        // x0 writeback discarded, then reset in the middle of a read
        step(); wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        rd_req_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd12;
        step(); wb_rd = 5'd9; wb_data = {$urandom, $urandom}; rs1 = 5'd7; rs2 = 5'd3; #1;
        chk("t6_rsp_valid", rd_rsp_valid, 1);
        chk("t6_rs1_x0", rs1_data, 64'd0);
        chk("t6_rs2_x12", rs2_data, x12_val);
        step(); idle_inputs(); #1;
        chk("t6_pending_count", wb_count, 1);
        chk("t6_rsp_before_reset", rd_rsp_valid, 1);
        reset = 1'b0; #1;
        chk("t6_reset_rsp_valid", rd_rsp_valid, 0);
        chk("t6_reset_wb_count", wb_count, 0);
        chk("t6_reset_write_en", rf_write_en, 0);
        step(); step();
        reset = 1'b1;

        // random traffic over a small register set to stress forwarding
        for (int n = 0; n < 1500; n++) begin
            step();
            rd_req_valid = ($urandom_range(0, 99) < 70);
            rs1          = 5'($urandom_range(0, 7));
            rs2          = 5'($urandom_range(0, 7));
            wb_valid     = ($urandom_range(0, 99) < 55);
            wb_rd        = 5'($urandom_range(0, 7));
            wb_data      = {$urandom, $urandom};
        end
        step(); idle_inputs();
        repeat (10) step();
        chk("drain_rsp_queue", rsp_q.size(), 0);
        chk("drain_wb_queue", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_access_sequencer.md
# regfile_access_sequencer

Sits directly upstream of the 32×64-bit user register file and owns its single shared read/write port. Accepts operand-read requests from decode and writeback results from execute/load, buffers writebacks in a small FIFO, and issues exactly one read or one write per cycle. Pending writebacks are forwarded to reads, so decode never sees a stale operand.

## Interface
Parameters:
- `XLEN`, 64, data width
- `WB_DEPTH`, 4, writeback FIFO entries (power of two, ≥2)
- `STARVE_MAX`, 4, max consecutive read issues while FIFO non-empty

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `rd_req_valid`  in  1  decode operand request
- `rd_req_ready`  out  1  request accepted when valid&ready
- `rs1`, `rs2`  in  5 each  source register indices
- `rd_rsp_valid`  out  1  operand response valid
- `rs1_data`, `rs2_data`  out  XLEN each  operand values
- `wb_valid`  in  1  writeback request
- `wb_ready`  out  1  writeback accepted when valid&ready
- `wb_rd`  in  5  destination index
- `wb_data`  in  XLEN  writeback value
- `rf_read_en`  out  1  to RF read enable
- `rf_data_read_1`, `rf_data_read_2`  out  5 each  to RF read addresses
- `rf_write_en`  out  5  to RF write address (0 = no write)
- `rf_data_in`  out  XLEN  to RF write data
- `rf_data_out_1`, `rf_data_out_2`  in  XLEN each  from RF, registered, valid the cycle after `rf_read_en`
- `wb_count`  out  clog2(WB_DEPTH)+1  FIFO occupancy

## Operation
- Each cycle is either a READ issue, a WRITE issue, or idle; never both. RF port outputs are driven combinationally from this decision.
- `rd_req_ready` = FIFO not full AND starve counter < STARVE_MAX.
- READ issue: `rd_req_valid & rd_req_ready`. Drive `rf_read_en`=1, addresses = rs1/rs2, `rf_write_en`=0.
- WRITE issue: no READ issue AND FIFO non-empty. Drive `rf_read_en`=0, `rf_write_en`=head.rd, `rf_data_in`=head.data; pop head.
- Idle: `rf_read_en`=0, `rf_write_en`=0, `rf_data_in`=0.
- Starve counter: increments on a READ issue while FIFO non-empty; clears on any WRITE issue or when FIFO empty. At STARVE_MAX, ready drops, forcing a WRITE.
- `wb_ready` = FIFO not full (registered occupancy; no same-cycle pop credit).
- Accepted wb with `wb_rd`=0 is consumed and discarded, never enqueued.
- Forwarding at READ issue, per operand, youngest match wins, in priority: same-cycle accepted wb (rd≠0), then FIFO entries newest→oldest, then RF. Match flag and value are registered for the response cycle.
- Response: `rs*_data` = 0 if index was 0, else forwarded value if matched, else `rf_data_out_*`.
- FIFO order preserved; duplicate rd entries allowed; drain order = acceptance order.

## Timing
- Reset values: `rd_rsp_valid`=0, `rs1_data`/`rs2_data`=0, `rf_read_en`=0, `rf_write_en`=0, `rf_data_in`=0, `wb_count`=0, `wb_ready`=1, `rd_req_ready`=1, FIFO empty, starve=0.
- Read latency: request accepted cycle N → `rd_rsp_valid`=1 in N+1 only (one-cycle pulse per request); back-to-back requests give back-to-back responses.
- Write latency: wb accepted in N → earliest WRITE issue N+1 → RF holds value after edge ending N+1.
- Full FIFO: `rd_req_ready`=0 and `wb_ready`=0; next cycle is a WRITE issue.
- Wrap-around: pointers wrap mod WB_DEPTH; occupancy distinguishes full/empty.
- Reset asserted mid-operation: FIFO contents and any outstanding response discarded; `rd_rsp_valid` deasserts immediately.

## Test plan
- After reset, wb x5=0xDEAD_BEEF; 3 idle cycles; read rs1=5, rs2=0 → response next cycle: 0xDEADBEEF, 0; `rf_write_en`=5 seen exactly once.
- Same-cycle wb x7=0x11 and read rs1=7 → response 0x11 (forwarded); RF write of x7 occurs following cycle.
- Enqueue x3=1, x3=2, x3=3 back-to-back, read rs1=3 immediately → 3 (youngest); RF later receives writes 1,2,3 in order.
- Fill FIFO (4 wb, continuous reads) → `wb_ready`=0 and `rd_req_ready`=0 at occupancy 4; next cycle WRITE issue, `wb_count`=3.
- Continuous `rd_req_valid` with 1 pending wb → 4 READ issues, then `rd_req_ready`=0 for one cycle with a WRITE issue.
- wb to x0 with 0xFF, read rs1=0 → 0; no RF write generated; pull `reset` low mid-read → `rd_rsp_valid`=0, `wb_count`=0 immediately.
